// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment driver: hex decode, leading-zero
// blanking, anti-ghost blank window and frame-aligned value updates.
module seg_scan_mux #(
  parameter int SCAN_DIV   = 10000,
  parameter int BLANK_CYC  = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_value_in,
  input  logic        i_load,
  input  logic [3:0]  i_dp_in,
  input  logic        i_blank_lz,
  output logic [6:0]  o_seg_out,
  output logic        o_dp_out,
  output logic [3:0]  o_dig_en,
  output logic        o_frame_done
);

  localparam logic [15:0] LP_LAST    = 16'(SCAN_DIV - 1);
  localparam logic [15:0] LP_BLANK   = 16'(BLANK_CYC);
  localparam logic [6:0]  LP_SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic        LP_DP_INV  = (ACTIVE_LOW != 0);
  localparam logic [3:0]  LP_EN_INV  = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_shadow_val;
  logic [3:0]  r_shadow_dp;
  logic        r_shadow_blz;
  logic        r_pending;
  logic [15:0] r_act_val;
  logic [3:0]  r_act_dp;
  logic        r_act_blz;

  logic        w_last;
  logic        w_boundary;
  logic [3:0]  w_nib;
  logic        w_blank;
  logic [6:0]  w_seg_dec;
  logic        w_dp_dec;
  logic [3:0]  w_en;

  assign w_last     = (r_cnt == LP_LAST);
  assign w_boundary = w_last && (r_idx == 2'd3);

  // Digit select and blanking: a digit is blank when it and every higher nibble are zero.
  always_comb begin
    w_nib   = r_act_val[3:0];
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib   = r_act_val[3:0];
        w_blank = 1'b0;
      end
      2'd1: begin
        w_nib   = r_act_val[7:4];
        w_blank = r_act_blz && (r_act_val[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib   = r_act_val[11:8];
        w_blank = r_act_blz && (r_act_val[15:8] == 8'h00);
      end
      default: begin
        w_nib   = r_act_val[15:12];
        w_blank = r_act_blz && (r_act_val[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_seg_dec = 7'h00;
    case (w_nib)
      4'h0: w_seg_dec = 7'h3F;
      4'h1: w_seg_dec = 7'h06;
      4'h2: w_seg_dec = 7'h5B;
      4'h3: w_seg_dec = 7'h4F;
      4'h4: w_seg_dec = 7'h66;
      4'h5: w_seg_dec = 7'h6D;
      4'h6: w_seg_dec = 7'h7D;
      4'h7: w_seg_dec = 7'h07;
      4'h8: w_seg_dec = 7'h7F;
      4'h9: w_seg_dec = 7'h6F;
      4'hA: w_seg_dec = 7'h77;
      4'hB: w_seg_dec = 7'h7C;
      4'hC: w_seg_dec = 7'h39;
      4'hD: w_seg_dec = 7'h5E;
      4'hE: w_seg_dec = 7'h79;
      default: w_seg_dec = 7'h71;
    endcase
    if (w_blank) w_seg_dec = 7'h00;
  end

  assign w_dp_dec = w_blank ? 1'b0 : r_act_dp[r_idx];
  assign w_en     = (r_cnt >= LP_BLANK) ? (4'b0001 << r_idx) : 4'b0000;

  // Slot counter, digit index and the shadow/active value pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= 16'd0;
      r_idx        <= 2'd0;
      r_shadow_val <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_shadow_blz <= 1'b0;
      r_pending    <= 1'b0;
      r_act_val    <= 16'h0000;
      r_act_dp     <= 4'h0;
      r_act_blz    <= 1'b0;
    end else begin
      if (w_last) begin
        r_cnt <= 16'd0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_boundary) begin
        // A load coinciding with the boundary bypasses the shadow.
        if (i_load) begin
          r_act_val <= i_value_in;
          r_act_dp  <= i_dp_in;
          r_act_blz <= i_blank_lz;
        end else if (r_pending) begin
          r_act_val <= r_shadow_val;
          r_act_dp  <= r_shadow_dp;
          r_act_blz <= r_shadow_blz;
        end
        r_pending <= 1'b0;
      end else if (i_load) begin
        r_shadow_val <= i_value_in;
        r_shadow_dp  <= i_dp_in;
        r_shadow_blz <= i_blank_lz;
        r_pending    <= 1'b1;
      end
    end
  end

  // Output registers; polarity inversion happens before the flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seg_out    <= LP_SEG_INV;
      o_dp_out     <= LP_DP_INV;
      o_dig_en     <= LP_EN_INV;
      o_frame_done <= 1'b0;
    end else begin
      o_seg_out    <= w_seg_dec ^ LP_SEG_INV;
      o_dp_out     <= w_dp_dec ^ LP_DP_INV;
      o_dig_en     <= w_en ^ LP_EN_INV;
      o_frame_done <= w_boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle-accurate reference model on both output
// polarities, a table of display patterns, and multi-cycle corner sequences.
module tb_seg_scan_mux;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0]  hi_seg, lo_seg;
  logic        hi_dp, lo_dp;
  logic [3:0]  hi_en, lo_en;
  logic        hi_fd, lo_fd;

  seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(0)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_value_in(value_in), .i_load(load),
    .i_dp_in(dp_in), .i_blank_lz(blank_lz),
    .o_seg_out(hi_seg), .o_dp_out(hi_dp), .o_dig_en(hi_en), .o_frame_done(hi_fd)
  );

  seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) u_dut_lo (
    .i_clk(clk), .i_rst(rst), .i_value_in(value_in), .i_load(load),
    .i_dp_in(dp_in), .i_blank_lz(blank_lz),
    .o_seg_out(lo_seg), .o_dp_out(lo_dp), .o_dig_en(lo_en), .o_frame_done(lo_fd)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          m_t;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dpv, s_dpv;
  logic        m_blz, s_blz, m_pend;

  // {frame_done, dig_en, dp, seg}
  logic [12:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int slot, pos;
    logic [15:0] sh;
    logic blank;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] e_en;
    logic bnd;
    if (rst) begin
      m_t = 0; m_val = 0; m_dpv = 0; m_blz = 0;
      s_val = 0; s_dpv = 0; s_blz = 0; m_pend = 0;
      exp_q.push_back(13'h0);
      return;
    end
    slot  = (m_t / SD) % 4;
    pos   = m_t % SD;
    sh    = m_val >> (4 * slot);
    blank = m_blz && (slot != 0) && (sh == 16'h0);
    e_seg = blank ? 7'h00 : seg_tab[sh[3:0]];
    e_dp  = blank ? 1'b0 : m_dpv[slot];
    e_en  = (pos >= BC) ? 4'(1 << slot) : 4'h0;
    bnd   = (slot == 3) && (pos == SD - 1);
    exp_q.push_back({bnd, e_en, e_dp, e_seg});
    if (bnd) begin
      if (load) begin m_val = value_in; m_dpv = dp_in; m_blz = blank_lz; end
      else if (m_pend) begin m_val = s_val; m_dpv = s_dpv; m_blz = s_blz; end
      m_pend = 0;
    end else if (load) begin
      s_val = value_in; s_dpv = dp_in; s_blz = blank_lz; m_pend = 1;
    end
    m_t++;
  endtask

  task automatic check_outputs();
    logic [12:0] e;
    logic [6:0] inv_seg;
    logic inv_dp;
    logic [3:0] inv_en;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    inv_seg = ~e[6:0];
    inv_dp  = ~e[7];
    inv_en  = ~e[11:8];
    check("seg", hi_seg, e[6:0]);
    check("dp", hi_dp, e[7]);
    check("dig_en", hi_en, e[11:8]);
    check("frame_done", hi_fd, e[12]);
    check("seg_al", lo_seg, inv_seg);
    check("dp_al", lo_dp, inv_dp);
    check("dig_en_al", lo_en, inv_en);
    check("frame_done_al", lo_fd, e[12]);
  endtask

  // ---------------- driver tasks ----------------
  logic [7:0] obs_seg [4];
  logic       obs_dp  [4];

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic tick_rec();
    tick();
    for (int k = 0; k < 4; k++)
      if (hi_en == 4'(1 << k)) begin
        obs_seg[k] = {1'b0, hi_seg};
        obs_dp[k]  = hi_dp;
      end
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 4; k++) begin
      obs_seg[k] = 8'hFF;
      obs_dp[k]  = 1'bx;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
    value_in = v; dp_in = d; blank_lz = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic align();
    for (int g = 0; g < 2 * FRAME && (m_t % FRAME) != 0; g++) tick_rec();
  endtask

  task automatic tick_until(input int phase);
    for (int g = 0; g < 2 * FRAME && (m_t % FRAME) != phase; g++) tick();
  endtask

  task automatic capture_frame();
    clear_obs();
    for (int c = 0; c < FRAME; c++) tick_rec();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        blz;
    logic [27:0] seg;   // digit3..digit0
    logic [3:0]  dpx;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000};
    vecs[2] = '{16'h0000, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};
    vecs[3] = '{16'hAAAA, 4'b0000, 1'b0, {7'h77, 7'h77, 7'h77, 7'h77}, 4'b0000};
    vecs[4] = '{16'h0F0F, 4'b1111, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h71}, 4'b0111};
    vecs[5] = '{16'h8000, 4'b1001, 1'b1, {7'h7F, 7'h3F, 7'h3F, 7'h3F}, 4'b1001};
    vecs[6] = '{16'h3C9E, 4'b0000, 1'b1, {7'h4F, 7'h39, 7'h6F, 7'h79}, 4'b0000};
    vecs[7] = '{16'h00B0, 4'b0010, 1'b0, {7'h3F, 7'h3F, 7'h7C, 7'h3F}, 4'b0010};

    rst = 1'b1; load = 1'b0; value_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    m_t = 0;
    clear_obs();

    // Reset: outputs off for both polarities.
    for (int c = 0; c < 3; c++) tick();
    check("rst_seg", hi_seg, 7'h00);
    check("rst_en", hi_en, 4'h0);
    check("rst_seg_al", lo_seg, 7'h7F);
    check("rst_en_al", lo_en, 4'hF);
    check("rst_dp_al", lo_dp, 1'b1);
    rst = 1'b0;

    // Table-driven display patterns.
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].val, vecs[i].dp, vecs[i].blz);
      align();
      capture_frame();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tbl%0d_seg%0d", i, k), obs_seg[k], {1'b0, vecs[i].seg[k*7 +: 7]});
        check($sformatf("tbl%0d_dp%0d", i, k), obs_dp[k], vecs[i].dpx[k]);
      end
    end

    // Tear-free: load mid-frame while 0xAAAA is active.
    do_load(16'hAAAA, 4'h0, 1'b0);
    align();
    tick_until(SD + 1);
    clear_obs();
    do_load(16'h1111, 4'h0, 1'b0);
    align();
    for (int k = 1; k < 4; k++) check($sformatf("tear_old%0d", k), obs_seg[k], 8'h77);
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("tear_new%0d", k), obs_seg[k], 8'h06);

    // Two loads in one frame: the last one wins.
    tick_until(2);
    do_load(16'h2222, 4'h0, 1'b0);
    tick(); tick(); tick();
    do_load(16'h3333, 4'h0, 1'b0);
    align();
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("last_wins%0d", k), obs_seg[k], 8'h4F);

    // Load exactly on the boundary edge.
    tick_until(FRAME - 1);
    do_load(16'h4444, 4'h0, 1'b0);
    capture_frame();
    for (int k = 0; k < 4; k++) check($sformatf("bnd_load%0d", k), obs_seg[k], 8'h66);

    // Mid-scan reset at idx=2, cnt=2.
    tick_until(2 * SD + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_en", hi_en, 4'h0);
    check("mrst_seg", hi_seg, 7'h00);
    check("mrst_fd", hi_fd, 1'b0);
    capture_frame();
    check("mrst_dig0", obs_seg[0], 8'h3F);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 7) == 0);
      value_in = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) value_in = value_in & 16'h00FF;
      dp_in    = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
